adc_scan_scheduler: RTL and testbench

Periodic multi-channel scan scheduler sitting in front of the ADC sequencer FSM. On every sample-period tick it walks the enabled channels in ascending order and, for each one, issues a conversion request, waits for end-of-conversion and emits one tagged sample. It flags overruns (a tick arriving while a scan is still running) and conversion timeouts, so software never stalls on a dead converter.

---
 rtl/adc_scan_scheduler.sv | 173 +++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_scheduler.sv
// Periodic multi-channel ADC scan scheduler: on each period tick, walks the enabled
// channels in ascending order, requests a conversion, waits for EOC and emits a tagged sample.
module adc_scan_scheduler #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned DATA_W  = 12,
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      en_in,
   input  logic [NUM_CH-1:0]         ch_en_in,
   input  logic [DIV_W-1:0]          period_in,
   output logic                      conv_req_out,
   output logic [$clog2(NUM_CH)-1:0] conv_ch_out,
   input  logic                      conv_ack_in,
   input  logic                      eoc_in,
   input  logic [DATA_W-1:0]         data_in,
   output logic                      sample_valid_out,
   output logic [$clog2(NUM_CH)-1:0] sample_ch_out,
   output logic [DATA_W-1:0]         sample_data_out,
   output logic                      overrun_out,
   output logic                      timeout_out,
   output logic                      busy_out,
   output logic [2:0]                state_out
);

   localparam int unsigned CW = $clog2(NUM_CH);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_TICK = 3'd1,
      S_REQ       = 3'd2,
      S_WAIT_EOC  = 3'd3,
      S_OUTPUT    = 3'd4
   } state_t;

   state_t              r_state;
   logic [DIV_W-1:0]    r_cnt;
   logic [TW-1:0]       r_tcnt;
   logic [NUM_CH-1:0]   r_pend;
   logic [CW-1:0]       r_ch;
   logic                r_req;
   logic                r_busy;
   logic                r_valid;
   logic [CW-1:0]       r_sch;
   logic [DATA_W-1:0]   r_sdata;
   logic                r_ovr;
   logic                r_tout;

   logic [DIV_W-1:0]    w_period;
   logic                w_tick;
   logic [NUM_CH-1:0]   w_pend_clr;
   logic [CW-1:0]       w_nxt_ch;

   function automatic logic [CW-1:0] f_lowest(input logic [NUM_CH-1:0] m);
      logic [CW-1:0] v;
      logic          found;
      v     = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (m[i] && !found) begin
            v     = CW'(i);
            found = 1'b1;
         end
      end
      return v;
   endfunction

   assign w_period   = (period_in < DIV_W'(2)) ? DIV_W'(2) : period_in;
   assign w_tick     = (r_state != S_IDLE) && (r_cnt >= w_period - DIV_W'(1));
   assign w_pend_clr = r_pend & ~(NUM_CH'(1) << r_ch);
   assign w_nxt_ch   = f_lowest(w_pend_clr);

   always_ff @(posedge clk_in) begin
      if (rst_in || !en_in) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_tcnt  <= '0;
         r_pend  <= '0;
         r_ch    <= '0;
         r_req   <= 1'b0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_sch   <= '0;
         r_sdata <= '0;
         r_ovr   <= 1'b0;
         r_tout  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_tout  <= 1'b0;
         r_sch   <= '0;
         r_sdata <= '0;
         if (r_state != S_IDLE)
            r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
         if (w_tick && (r_state == S_REQ || r_state == S_WAIT_EOC || r_state == S_OUTPUT))
            r_ovr <= 1'b1;
         case (r_state)
            S_IDLE: begin
               r_cnt   <= '0;
               r_state <= S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
               if (w_tick && ch_en_in != '0) begin
                  r_pend  <= ch_en_in;
                  r_ch    <= f_lowest(ch_en_in);
                  r_req   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (conv_ack_in) begin
                  r_req   <= 1'b0;
                  r_tcnt  <= '0;
                  r_state <= S_WAIT_EOC;
               end
            end
            S_WAIT_EOC: begin
               // The pulse is raised while still in WAIT_EOC; the channel is abandoned a cycle later.
               if (r_tcnt == TW'(TIMEOUT)) begin
                  r_pend <= w_pend_clr;
                  if (w_pend_clr != '0) begin
                     r_ch    <= w_nxt_ch;
                     r_req   <= 1'b1;
                     r_state <= S_REQ;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= S_WAIT_TICK;
                  end
               end else if (eoc_in) begin
                  r_valid <= 1'b1;
                  r_sch   <= r_ch;
                  r_sdata <= data_in;
                  r_state <= S_OUTPUT;
               end else begin
                  if (r_tcnt == TW'(TIMEOUT - 1))
                     r_tout <= 1'b1;
                  r_tcnt <= r_tcnt + TW'(1);
               end
            end
            S_OUTPUT: begin
               r_pend <= w_pend_clr;
               if (w_pend_clr != '0) begin
                  r_ch    <= w_nxt_ch;
                  r_req   <= 1'b1;
                  r_state <= S_REQ;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_WAIT_TICK;
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign conv_req_out     = r_req;
   assign conv_ch_out      = r_ch;
   assign sample_valid_out = r_valid;
   assign sample_ch_out    = r_sch;
   assign sample_data_out  = r_sdata;
   assign overrun_out      = r_ovr;
   assign timeout_out      = r_tout;
   assign busy_out         = r_busy;
   assign state_out        = r_state;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Scoreboard bench for adc_scan_scheduler: directed scenarios push expected samples,
// a negedge monitor pops and compares whenever sample_valid_out is seen.
module tb_adc_scan_scheduler;

   logic        clk_in;
   logic        rst_in;
   logic        en_in;
   logic [3:0]  ch_en_in;
   logic [15:0] period_in;
   logic        conv_req_out;
   logic [1:0]  conv_ch_out;
   logic        conv_ack_in;
   logic        eoc_in;
   logic [11:0] data_in;
   logic        sample_valid_out;
   logic [1:0]  sample_ch_out;
   logic [11:0] sample_data_out;
   logic        overrun_out;
   logic        timeout_out;
   logic        busy_out;
   logic [2:0]  state_out;

   adc_scan_scheduler #(
      .NUM_CH (4),
      .DATA_W (12),
      .DIV_W  (16),
      .TIMEOUT(16)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .en_in           (en_in),
      .ch_en_in        (ch_en_in),
      .period_in       (period_in),
      .conv_req_out    (conv_req_out),
      .conv_ch_out     (conv_ch_out),
      .conv_ack_in     (conv_ack_in),
      .eoc_in          (eoc_in),
      .data_in         (data_in),
      .sample_valid_out(sample_valid_out),
      .sample_ch_out   (sample_ch_out),
      .sample_data_out (sample_data_out),
      .overrun_out     (overrun_out),
      .timeout_out     (timeout_out),
      .busy_out        (busy_out),
      .state_out       (state_out)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int tout_cnt    = 0;
   int scan_q[$];
   logic [13:0] sb[$];
   logic [2:0]  prev_state = 3'd0;

   // Sequencer model knobs
   int         ack_dly  = 0;
   int         eoc_dly  = 0;
   logic       withhold = 1'b0;
   logic [1:0] hold_ch  = 2'd0;
   logic       chk_hold = 1'b0;
   logic [1:0] exp_ch   = 2'd0;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_push(input logic [1:0] ch);
      sb.push_back({ch, 12'h100 + 12'(ch)});
   endtask

   task automatic step_to(input int target);
      while (cyc < target) @(negedge clk_in);
   endtask

   task automatic wait_req(input int maxc, output int at);
      at = -1;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk_in);
         if (conv_req_out) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         vectors++;
         miscompares++;
         $display("FAIL req_wait: no conv_req_out within %0d cycles, required one", maxc);
      end
   endtask

   task automatic wait_sb_empty(input int maxc, input string name);
      int i = 0;
      while (sb.size() != 0 && i < maxc) begin
         @(negedge clk_in);
         #1;
         i++;
      end
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: %0d samples outstanding after %0d cycles, required 0", name, sb.size(), maxc);
         sb.delete();
      end
   endtask

   task automatic disable_and_settle();
      en_in = 1'b0;
      repeat (3) @(negedge clk_in);
   endtask

   // Monitor: scoreboard pops, timeout pulses and scan starts
   always @(negedge clk_in) begin
      if (sample_valid_out) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sample_unexpected: got ch%0d data 0x%0h, expected no sample", sample_ch_out, sample_data_out);
         end else begin
            logic [13:0] e;
            e = sb.pop_front();
            chk("sample", 32'({sample_ch_out, sample_data_out}), 32'(e));
         end
      end
      if (timeout_out) tout_cnt++;
      if (state_out == 3'd2 && prev_state == 3'd1) scan_q.push_back(cyc);
      prev_state = state_out;
   end

   // Sequencer model: ack after ack_dly cycles, eoc eoc_dly cycles after the ack cycle
   initial begin : responder
      logic [1:0] rch;
      conv_ack_in = 1'b0;
      eoc_in      = 1'b0;
      data_in     = '0;
      forever begin
         @(negedge clk_in);
         if (conv_req_out) begin
            rch = conv_ch_out;
            for (int i = 0; i < ack_dly; i++) begin
               if (chk_hold) begin
                  chk("hold_req", 32'(conv_req_out), 1);
                  chk("hold_ch", 32'(conv_ch_out), 32'(exp_ch));
               end
               @(negedge clk_in);
            end
            conv_ack_in = 1'b1;
            @(negedge clk_in);
            conv_ack_in = 1'b0;
            if (chk_hold) chk("ack_release", 32'(conv_req_out), 0);
            if (!(withhold && rch == hold_ch)) begin
               for (int i = 0; i < eoc_dly; i++) @(negedge clk_in);
               eoc_in  = 1'b1;
               data_in = 12'h100 + 12'(rch);
               @(negedge clk_in);
               eoc_in  = 1'b0;
               data_in = '0;
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int c0, r, s;
      rst_in    = 1'b1;
      en_in     = 1'b1;
      ch_en_in  = 4'b1111;
      period_in = 16'd4;

      // Reset holds everything at zero even with enable high
      repeat (3) @(negedge clk_in);
      chk("rst_state", 32'(state_out), 0);
      chk("rst_req", 32'(conv_req_out), 0);
      chk("rst_busy", 32'(busy_out), 0);
      chk("rst_ovr", 32'(overrun_out), 0);
      chk("rst_valid", 32'(sample_valid_out), 0);
      chk("rst_tout", 32'(timeout_out), 0);
      en_in  = 1'b0;
      rst_in = 1'b0;
      repeat (2) @(negedge clk_in);

      // Scan of ch0,1,3 every 20 cycles, no overrun
      period_in = 16'd20; ch_en_in = 4'b1011; ack_dly = 2; eoc_dly = 1;
      scan_q.delete();
      for (int k = 0; k < 3; k++) begin
         exp_push(2'd0); exp_push(2'd1); exp_push(2'd3);
      end
      c0 = cyc;
      en_in = 1'b1;
      wait_sb_empty(200, "t1_samples");
      chk("t1_ovr", 32'(overrun_out), 0);
      disable_and_settle();
      chk("t1_scans", scan_q.size(), 3);
      if (scan_q.size() == 3) begin
         chk("t1_first_req", scan_q[0] - c0, 21);
         chk("t1_period_a", scan_q[1] - scan_q[0], 20);
         chk("t1_period_b", scan_q[2] - scan_q[1], 20);
      end

      // Overrun: period 5, long eoc latency
      period_in = 16'd5; ch_en_in = 4'b1111; ack_dly = 0; eoc_dly = 10;
      for (int k = 0; k < 2; k++)
         for (int ch = 0; ch < 4; ch++) exp_push(2'(ch));
      en_in = 1'b1;
      wait_req(20, s);
      chk("t2_ovr_start", 32'(overrun_out), 0);
      step_to(s + 4);
      chk("t2_ovr_before", 32'(overrun_out), 0);
      step_to(s + 5);
      chk("t2_ovr_set", 32'(overrun_out), 1);
      wait_sb_empty(300, "t2_samples");
      chk("t2_ovr_sticky", 32'(overrun_out), 1);
      en_in = 1'b0;
      @(negedge clk_in);
      chk("t2_ovr_clear", 32'(overrun_out), 0);
      chk("t2_idle", 32'(state_out), 0);
      repeat (2) @(negedge clk_in);

      // Timeout on ch2
      period_in = 16'd40; ch_en_in = 4'b0100; ack_dly = 0; eoc_dly = 1;
      withhold = 1'b1; hold_ch = 2'd2; tout_cnt = 0;
      en_in = 1'b1;
      wait_req(60, r);
      chk("t3_ch", 32'(conv_ch_out), 2);
      step_to(r + 16);
      chk("t3_tout_early", 32'(timeout_out), 0);
      chk("t3_state_wait", 32'(state_out), 3);
      step_to(r + 17);
      chk("t3_tout_pulse", 32'(timeout_out), 1);
      chk("t3_busy_pulse", 32'(busy_out), 1);
      step_to(r + 18);
      chk("t3_tout_end", 32'(timeout_out), 0);
      chk("t3_state_back", 32'(state_out), 1);
      chk("t3_busy_end", 32'(busy_out), 0);
      chk("t3_tout_count", tout_cnt, 1);
      disable_and_settle();
      withhold = 1'b0;

      // EOC on the last cycle before timeout wins
      ch_en_in = 4'b0001; eoc_dly = 15; tout_cnt = 0;
      exp_push(2'd0);
      en_in = 1'b1;
      wait_req(60, r);
      wait_sb_empty(40, "t3b_sample");
      chk("t3b_latency", cyc - r, 17);
      chk("t3b_no_tout", tout_cnt, 0);
      disable_and_settle();

      // Ack held off 7 cycles; mid-scan mask change is ignored
      ch_en_in = 4'b0010; ack_dly = 7; eoc_dly = 1; exp_ch = 2'd1; chk_hold = 1'b1;
      exp_push(2'd1);
      en_in = 1'b1;
      wait_req(60, r);
      step_to(r + 2);
      ch_en_in = 4'b1111;
      wait_sb_empty(40, "t4_sample");
      disable_and_settle();
      chk_hold = 1'b0;

      // Abort during WAIT_EOC, then re-enable
      period_in = 16'd20; ch_en_in = 4'b0001; ack_dly = 0; eoc_dly = 10;
      en_in = 1'b1;
      wait_req(40, r);
      step_to(r + 3);
      chk("t5_in_wait", 32'(state_out), 3);
      en_in = 1'b0;
      step_to(r + 5);
      chk("t5_idle", 32'(state_out), 0);
      step_to(r + 14);
      chk("t5_still_idle", 32'(state_out), 0);
      chk("t5_no_req", 32'(conv_req_out), 0);
      exp_push(2'd0);
      c0 = cyc;
      en_in = 1'b1;
      wait_req(40, r);
      chk("t5_reenable_req", r - c0, 21);
      wait_sb_empty(40, "t5_sample");
      disable_and_settle();

      // Period 0 clamps to 2; empty mask never requests
      period_in = 16'd0; ch_en_in = 4'b0000; ack_dly = 0; eoc_dly = 0;
      scan_q.delete();
      en_in = 1'b1;
      repeat (30) @(negedge clk_in);
      chk("t6_no_scans", scan_q.size(), 0);
      chk("t6_no_ovr", 32'(overrun_out), 0);
      repeat (3) exp_push(2'd0);
      ch_en_in = 4'b0001;
      wait_req(10, s);
      step_to(s + 1);
      chk("t6_ovr_before", 32'(overrun_out), 0);
      step_to(s + 2);
      chk("t6_ovr_set", 32'(overrun_out), 1);
      wait_sb_empty(30, "t6_samples");
      disable_and_settle();
      chk("t6_scans", scan_q.size(), 3);
      if (scan_q.size() >= 2) chk("t6_spacing", scan_q[1] - scan_q[0], 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
